// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM time-base stage.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH   = 16;
  localparam int unsigned PWM_PRESC_W = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Settings the generator must only see change at a period boundary
  typedef struct packed {
    logic [PWM_PRESC_W-1:0] prescale;
    logic [PWM_WIDTH-1:0]   period;
    logic [PWM_WIDTH-1:0]   compare1;
    logic [PWM_WIDTH-1:0]   compare2;
  } shadow_t;

endpackage

// File: rtl/pwm_counter_if.sv
// Control/config bus into the time base and shadowed outputs toward the generator.
interface pwm_counter_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = PWM_WIDTH,
  parameter int unsigned PRESC_W = PWM_PRESC_W
);

  logic               count_en;
  logic               count_reset;
  logic               upnotdown;
  logic [PRESC_W-1:0] prescale_in;
  logic [WIDTH-1:0]   period_in;
  logic [WIDTH-1:0]   compare1_in;
  logic [WIDTH-1:0]   compare2_in;
  logic [WIDTH-1:0]   count_val;
  logic [WIDTH-1:0]   period;
  logic [WIDTH-1:0]   compare1;
  logic [WIDTH-1:0]   compare2;
  logic               ovf;
  logic               udf;

  modport master (
    output count_en, count_reset, upnotdown, prescale_in,
           period_in, compare1_in, compare2_in,
    input  count_val, period, compare1, compare2, ovf, udf
  );

  modport slave (
    input  count_en, count_reset, upnotdown, prescale_in,
           period_in, compare1_in, compare2_in,
    output count_val, period, compare1, compare2, ovf, udf
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider: tick_c fires once every prescale+1 enabled clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC_W = PWM_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick_c
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick_c = en && (presc_cnt == prescale);

  // Holds while disabled; clr wins over everything so the next period starts clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr || tick_c) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_counter.sv
// PWM time base: prescaled up/down counter with period-boundary shadowing of
// period/compare settings and single-cycle overflow/underflow events.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = PWM_WIDTH,
  parameter int unsigned PRESC_W = PWM_PRESC_W
) (
  input logic           clk,
  input logic           rst,
  pwm_counter_if.slave  bus
);

  shadow_t            sh_q;
  shadow_t            sh_in_c;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   per_sh_c;
  logic [PRESC_W-1:0] presc_in_c;
  logic               ovf_q;
  logic               udf_q;
  logic               tick_c;
  dir_e               dir_c;

  assign presc_in_c = bus.prescale_in;
  assign dir_c      = dir_e'(bus.upnotdown);
  assign per_sh_c   = WIDTH'(sh_q.period);

  assign sh_in_c = '{
    prescale: PWM_PRESC_W'(presc_in_c),
    period:   PWM_WIDTH'(bus.period_in),
    compare1: PWM_WIDTH'(bus.compare1_in),
    compare2: PWM_WIDTH'(bus.compare2_in)
  };

  pwm_prescaler #(
    .PRESC_W (PWM_PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.count_en),
    .clr      (bus.count_reset),
    .prescale (sh_q.prescale),
    .tick_c   (tick_c)
  );

  // Count engine; every wrap, clear and stopped cycle reloads the shadow set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      if (bus.count_reset) begin
        cnt_q <= '0;
        sh_q  <= sh_in_c;
      end else if (!bus.count_en) begin
        sh_q  <= sh_in_c;
      end else if (tick_c) begin
        if (dir_c == DIR_UP) begin
          if (cnt_q == per_sh_c) begin
            cnt_q <= '0;
            ovf_q <= 1'b1;
            sh_q  <= sh_in_c;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end else begin
          // Down wrap restarts from the freshly loaded period, not the old one
          if (cnt_q == '0) begin
            cnt_q <= bus.period_in;
            udf_q <= 1'b1;
            sh_q  <= sh_in_c;
          end else begin
            cnt_q <= cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.count_val = cnt_q;
  assign bus.period    = per_sh_c;
  assign bus.compare1  = WIDTH'(sh_q.compare1);
  assign bus.compare2  = WIDTH'(sh_q.compare2);
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter: cycle model feeds a scoreboard queue, plus
// literal checks of the key sequences.
module tb_pwm_counter;

  logic clk;
  logic rst;

  pwm_counter_if bus ();

  pwm_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] per;
    logic [15:0] c1;
    logic [15:0] c2;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_cnt, m_per, m_c1, m_c2;
  logic [7:0]  m_presc, m_psh;

  task automatic model_reset();
    m_cnt = '0; m_per = '0; m_c1 = '0; m_c2 = '0; m_presc = '0; m_psh = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock, queue its prediction, then compare after the edge
  task automatic cycle();
    exp_t e;
    exp_t got;
    exp_t obs;
    logic tk;
    logic ld;
    ld = 1'b0;
    e  = '0;
    tk = bus.count_en && (m_presc == m_psh);
    if (bus.count_reset) begin
      m_cnt = '0; m_presc = '0; ld = 1'b1;
    end else if (!bus.count_en) begin
      ld = 1'b1;
    end else if (!tk) begin
      m_presc = m_presc + 8'd1;
    end else begin
      m_presc = '0;
      if (bus.upnotdown) begin
        if (m_cnt == m_per) begin m_cnt = '0; e.ovf = 1'b1; ld = 1'b1; end
        else m_cnt = m_cnt + 16'd1;
      end else begin
        if (m_cnt == 16'd0) begin m_cnt = bus.period_in; e.udf = 1'b1; ld = 1'b1; end
        else m_cnt = m_cnt - 16'd1;
      end
    end
    if (ld) begin
      m_psh = bus.prescale_in; m_per = bus.period_in;
      m_c1  = bus.compare1_in; m_c2  = bus.compare2_in;
    end
    e.cnt = m_cnt; e.per = m_per; e.c1 = m_c1; e.c2 = m_c2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    obs = {bus.count_val, bus.period, bus.compare1, bus.compare2, bus.ovf, bus.udf};
    n_tests++;
    assert (obs === got) else begin
      n_fail++;
      $error("FAIL sb observed cnt=%0d per=%0d c1=%0d c2=%0d ovf=%b udf=%b expected cnt=%0d per=%0d c1=%0d c2=%0d ovf=%b udf=%b",
             obs.cnt, obs.per, obs.c1, obs.c2, obs.ovf, obs.udf,
             got.cnt, got.per, got.c1, got.c2, got.ovf, got.udf);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, bus.count_val, 0);
    chk({tag, "_per"}, bus.period, 0);
    chk({tag, "_c1"},  bus.compare1, 0);
    chk({tag, "_c2"},  bus.compare2, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_udf"}, bus.udf, 0);
  endtask

  // Reset lands between edges; outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_a[10];
    int exp_c[8];
    int n_ovf;

    rst = 1'b1;
    bus.count_en = 1'b0; bus.count_reset = 1'b0; bus.upnotdown = 1'b1;
    bus.prescale_in = '0; bus.period_in = '0; bus.compare1_in = '0; bus.compare2_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // Up count, period 4, no prescale
    bus.period_in = 16'd4; bus.compare1_in = 16'd2; bus.compare2_in = 16'd3;
    cycle();
    chk("a_load_per", bus.period, 4);
    bus.count_en = 1'b1;
    exp_a = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("a_cnt", bus.count_val, exp_a[i]);
      chk("a_ovf", bus.ovf, (exp_a[i] == 0) ? 1 : 0);
    end

    // Prescale 2, period 3: each value held 3 clocks, wrap every 12
    bus.prescale_in = 8'd2; bus.period_in = 16'd3; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    n_ovf = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_ovf += int'(bus.ovf);
      if (i == 1)  chk("b_hold", bus.count_val, 0);
      if (i == 2)  chk("b_step", bus.count_val, 1);
      if (i == 11) chk("b_ovf12", bus.ovf, 1);
    end
    chk("b_ovf_total", n_ovf, 2);

    // Down count from reset, period 3
    do_reset();
    bus.count_en = 1'b0; bus.upnotdown = 1'b0; bus.prescale_in = '0; bus.period_in = 16'd3;
    cycle();
    bus.count_en = 1'b1;
    exp_c = '{3, 2, 1, 0, 3, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("c_cnt", bus.count_val, exp_c[i]);
      chk("c_udf", bus.udf, (exp_c[i] == 3) ? 1 : 0);
      chk("c_ovf", bus.ovf, 0);
    end

    // Config written mid-period only appears at the wrap
    bus.upnotdown = 1'b1; bus.period_in = 16'd9; bus.compare1_in = 16'd7; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    repeat (3) cycle();
    chk("d_cnt3", bus.count_val, 3);
    bus.period_in = 16'd5; bus.compare1_in = 16'd2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("d_old_per", bus.period, 9);
      chk("d_old_c1", bus.compare1, 7);
    end
    cycle();
    chk("d_wrap_cnt", bus.count_val, 0);
    chk("d_new_per", bus.period, 5);
    chk("d_new_c1", bus.compare1, 2);
    chk("d_wrap_ovf", bus.ovf, 1);

    // count_reset at 7 beats the due tick; then freeze at 6 and resume
    bus.period_in = 16'd9; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    repeat (7) cycle();
    chk("e_cnt7", bus.count_val, 7);
    bus.count_reset = 1'b1; bus.compare2_in = 16'd11;
    cycle();
    bus.count_reset = 1'b0;
    chk("e_clr_cnt", bus.count_val, 0);
    chk("e_clr_ovf", bus.ovf, 0);
    chk("e_clr_c2", bus.compare2, 11);
    repeat (6) cycle();
    bus.count_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("e_frozen", bus.count_val, 6);
    end
    bus.count_en = 1'b1;
    cycle();
    chk("e_resume", bus.count_val, 7);
    bus.upnotdown = 1'b0;
    cycle();
    chk("e_dir_dn", bus.count_val, 6);
    chk("e_dir_udf", bus.udf, 0);
    bus.upnotdown = 1'b1;
    cycle();
    chk("e_dir_up", bus.count_val, 7);

    // period 0: every tick is a wrap
    bus.period_in = '0; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("f_cnt", bus.count_val, 0);
      chk("f_ovf", bus.ovf, 1);
    end
    bus.prescale_in = 8'd1; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("f_presc_ovf", bus.ovf, (i % 2 == 1) ? 1 : 0);
    end

    // Reset mid-count, then resume from a clean state
    bus.prescale_in = '0; bus.period_in = 16'd9; bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
    repeat (4) cycle();
    chk("g_cnt4", bus.count_val, 4);
    do_reset();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_counter.md
# pwm_counter

Time-base stage that sits directly upstream of the PWM generator. It produces the free-running `count_val` that the generator compares against, and applies a programmable prescaler and up/down counting. It double-buffers `period`, `compare1` and `compare2` so that the generator only ever sees new settings at a period boundary, and it emits single-cycle overflow/underflow events.

## Interface
- `WIDTH`, default 16: width of the counter, period and compare values.
- `PRESC_W`, default 8: width of the prescaler setting.
- `clk`  in  1  peripheral clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `count_en`  in  1  1 = counting; 0 = counter and prescaler frozen, shadows transparent.
- `count_reset`  in  1  synchronous clear pulse.
- `upnotdown`  in  1  1 = count up, 0 = count down.
- `prescale_in`  in  PRESC_W  the count advances once per `prescale_in+1` clocks.
- `period_in`, `compare1_in`, `compare2_in`  in  WIDTH each  configuration values from the register file.
- `count_val`  out  WIDTH  current count, consumed by the generator.
- `period`, `compare1`, `compare2`  out  WIDTH each  shadowed values, consumed by the generator.
- `ovf`  out  1  one-cycle pulse on an up-count wrap.
- `udf`  out  1  one-cycle pulse on a down-count wrap.

## Operation
- Reset: every output is 0, the prescaler counter is 0, and the prescale shadow is 0.
- Shadow set is `prescale_sh`, `period`, `compare1` and `compare2`. Shadows load from the inputs:
  - every cycle while `count_en`=0;
  - on every wrap event;
  - on `count_reset`.
  - At no other time.
- Prescaler:
  - `presc_cnt` increments while `count_en`=1.
  - `tick` = `count_en` && (`presc_cnt` == `prescale_sh`). On `tick`, `presc_cnt` returns to 0.
- Up mode, on `tick`:
  - if `count_val` == `period`: `count_val`←0, `ovf`←1, shadows load;
  - else `count_val`←`count_val`+1.
- Down mode, on `tick`:
  - if `count_val` == 0: shadows load, `count_val`←`period_in` (the new value), `udf`←1;
  - else `count_val`←`count_val`−1.
- `period`=0: `count_val` stays 0 and every tick is a wrap event, so `ovf` or `udf` is asserted on each tick.
- A `count_val` above `period` cannot arise in up mode; if it is forced by a direction change, up mode still increments until `count_val` == `period` through modulo-2^WIDTH wrap. No saturation.
- Direction change takes effect on the next tick, with no event and no reload.
- `count_reset` has priority over `tick`: `count_val`←0, `presc_cnt`←0, shadows load, no `ovf`/`udf`.
- `count_en` falling: `count_val` and `presc_cnt` hold their values and are not cleared. Resuming continues from the held state.
- `ovf`/`udf` are registered. They are 0 in every cycle without a wrap and are never asserted together.

## Timing
- `count_val`, the shadow outputs and `ovf`/`udf` all change on the same edge: the edge that samples `tick`=1.
- `ovf` is high in the cycle where `count_val` first reads 0.
- Up-mode wrap period = (`period`+1)·(`prescale_sh`+1) clocks.
- Input-to-output latency:
  - stopped: 1 clock for config inputs to reach the shadows;
  - running: at the next wrap.
- Asserting `rst` mid-count clears all state immediately, without waiting for an edge. After `rst` deasserts, the first tick occurs `prescale_sh`+1 enabled clocks later.

## Structure
- Package `pwm_pkg` holds:
  - `PWM_WIDTH`=16 and `PWM_PRESC_W`=8;
  - direction constants `DIR_UP`=1 and `DIR_DOWN`=0;
  - the shadow-set struct type (prescale, period, compare1, compare2).
- Sub-module `pwm_prescaler` holds `presc_cnt`, the `prescale_sh` compare and `tick` generation, with inputs `clk`, `rst`, `en`, `clr`, `prescale`. The shadow register set and the count FSM stay in `pwm_counter`.

## Test plan
- Up count, `period`=4, `prescale_in`=0, `count_en`=1 → `count_val` sequence 0,1,2,3,4,0…; `ovf` high for 1 clock every 5 clocks, aligned with 0.
- `prescale_in`=2, `period`=3 → each count value is held 3 clocks; `ovf` every 12 clocks.
- Down mode, `period`=3, starting from reset → 0,3,2,1,0,3…; `udf` on each transition to 3; `ovf` stays 0.
- Running with `period`=9; write `period_in`=5 and `compare1_in`=2 at count 3 → outputs keep 9 and the old compare until the wrap; 5 and 2 appear together with `count_val`=0.
- `count_reset` at count 7 while a tick is due → `count_val`=0 and `presc_cnt`=0 next cycle, shadows updated, no `ovf`. Also: `count_en`=0 at count 6 for 10 clocks → `count_val` stays 6, then resumes 7.
- `period`=0 → `count_val` constant 0 and `ovf` asserted on every tick. Also: `rst` asserted mid-period → all outputs 0 asynchronously.
